// File: rtl/bp_mem_fixed_latency_responder.sv
// Fixed-latency memory responder for the CCE memory interface.
// Accepts one read or writeback at a time, serves it from a local block RAM,
// and answers after latency_p cycles; writebacks win when both are valid.
module bp_mem_fixed_latency_responder #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int els_p           = 1024,
  parameter int latency_p       = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic                       mem_cmd_v_i,
  input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
  input  logic [payload_width_p-1:0] mem_cmd_payload_i,
  output logic                       mem_cmd_yumi_o,

  input  logic                       mem_data_cmd_v_i,
  input  logic [paddr_width_p-1:0]   mem_data_cmd_addr_i,
  input  logic [payload_width_p-1:0] mem_data_cmd_payload_i,
  input  logic [block_width_p-1:0]   mem_data_cmd_data_i,
  output logic                       mem_data_cmd_yumi_o,

  output logic                       mem_resp_v_o,
  output logic [paddr_width_p-1:0]   mem_resp_addr_o,
  output logic [payload_width_p-1:0] mem_resp_payload_o,
  input  logic                       mem_resp_ready_i,

  output logic                       mem_data_resp_v_o,
  output logic [paddr_width_p-1:0]   mem_data_resp_addr_o,
  output logic [payload_width_p-1:0] mem_data_resp_payload_o,
  output logic [block_width_p-1:0]   mem_data_resp_data_o,
  input  logic                       mem_data_resp_ready_i
);

  localparam int offset_w_lp = $clog2(block_width_p / 8);
  localparam int idx_w_lp    = $clog2(els_p);
  localparam int cnt_w_lp    = (latency_p > 1) ? $clog2(latency_p) : 1;
  localparam logic [cnt_w_lp-1:0] cnt_load_lp = cnt_w_lp'(latency_p - 1);

  // Elaboration-time parameter sanity checks
  if (latency_p < 1) begin : g_bad_latency
    $error("latency_p must be >= 1");
  end
  if ((els_p < 1) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
    $error("els_p must be a power of 2");
  end
  if ((block_width_p < 64) || ((block_width_p & (block_width_p - 1)) != 0)) begin : g_bad_block
    $error("block_width_p must be a power of 2 and >= 64");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                     state_q, state_d;
  logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
  logic [paddr_width_p-1:0]   addr_q, addr_d;
  logic [payload_width_p-1:0] payload_q, payload_d;
  logic                       is_wr_q, is_wr_d;
  logic [block_width_p-1:0]   data_q, data_d;

  logic [block_width_p-1:0]   mem [els_p];
  logic                       wr_en;
  logic [idx_w_lp-1:0]        wr_idx;
  logic [idx_w_lp-1:0]        rd_idx;
  logic [block_width_p-1:0]   rd_data;
  logic                       resp_v;
  logic                       data_resp_v;
  logic                       handshake;

  // Offset and upper address bits are dropped, so blocks alias modulo els_p
  assign wr_idx  = mem_data_cmd_addr_i[offset_w_lp +: idx_w_lp];
  assign rd_idx  = addr_q[offset_w_lp +: idx_w_lp];
  assign rd_data = mem[rd_idx];

  assign resp_v      = (state_q == S_RESP) &  is_wr_q;
  assign data_resp_v = (state_q == S_RESP) & ~is_wr_q;
  assign handshake   = (resp_v & mem_resp_ready_i) | (data_resp_v & mem_data_resp_ready_i);

  assign mem_resp_v_o            = resp_v;
  assign mem_resp_addr_o         = addr_q;
  assign mem_resp_payload_o      = payload_q;
  assign mem_data_resp_v_o       = data_resp_v;
  assign mem_data_resp_addr_o    = addr_q;
  assign mem_data_resp_payload_o = payload_q;
  assign mem_data_resp_data_o    = data_q;

  // Next-state, accept handshake and transaction capture
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    addr_d              = addr_q;
    payload_d           = payload_q;
    is_wr_d             = is_wr_q;
    data_d              = data_q;
    wr_en               = 1'b0;
    mem_cmd_yumi_o      = 1'b0;
    mem_data_cmd_yumi_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Gated by reset so nothing is consumed while reset is held
        mem_data_cmd_yumi_o = reset_n_i & mem_data_cmd_v_i;
        mem_cmd_yumi_o      = reset_n_i & mem_cmd_v_i & ~mem_data_cmd_v_i;
        if (mem_data_cmd_yumi_o) begin
          addr_d    = mem_data_cmd_addr_i;
          payload_d = mem_data_cmd_payload_i;
          is_wr_d   = 1'b1;
          cnt_d     = cnt_load_lp;
          wr_en     = 1'b1;
          state_d   = S_WAIT;
        end else if (mem_cmd_yumi_o) begin
          addr_d    = mem_cmd_addr_i;
          payload_d = mem_cmd_payload_i;
          is_wr_d   = 1'b0;
          cnt_d     = cnt_load_lp;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!is_wr_q) begin
            data_d = rd_data;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - cnt_w_lp'(1);
        end
      end
      S_RESP: begin
        if (handshake) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      payload_q <= '0;
      is_wr_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      is_wr_q   <= is_wr_d;
      data_q    <= data_d;
    end
  end

  // Block RAM write port; contents are not reset
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= mem_data_cmd_data_i;
    end
  end

endmodule

// File: tb/tb_bp_mem_fixed_latency_responder.sv
// Directed bench for bp_mem_fixed_latency_responder: instance A uses the default
// latency of 8 with 512-bit blocks, instance B uses latency 1 with 64-bit blocks.
module tb_bp_mem_fixed_latency_responder;

  logic clk;
  logic reset_n;

  logic [39:0]  addr;
  logic [15:0]  payload;
  logic [511:0] wdata;
  logic [63:0]  b_wdata;

  logic a_cmd_v, a_cmd_yumi, a_dc_v, a_dc_yumi;
  logic a_resp_v, a_resp_rdy, a_dresp_v, a_dresp_rdy;
  logic [39:0]  a_resp_addr, a_dresp_addr;
  logic [15:0]  a_resp_pl, a_dresp_pl;
  logic [511:0] a_dresp_data;

  logic b_cmd_v, b_cmd_yumi, b_dc_v, b_dc_yumi;
  logic b_resp_v, b_resp_rdy, b_dresp_v, b_dresp_rdy;
  logic [39:0] b_resp_addr, b_dresp_addr;
  logic [15:0] b_resp_pl, b_dresp_pl;
  logic [63:0] b_dresp_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [511:0] D1 = {16{32'hA5A5_0001}};
  localparam logic [511:0] D2 = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [511:0] D4 = {16{32'hDEAD_0004}};

  bp_mem_fixed_latency_responder #(
    .paddr_width_p(40), .block_width_p(512), .payload_width_p(16),
    .els_p(1024), .latency_p(8)
  ) dut_a (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_v_i(a_cmd_v), .mem_cmd_addr_i(addr), .mem_cmd_payload_i(payload),
    .mem_cmd_yumi_o(a_cmd_yumi),
    .mem_data_cmd_v_i(a_dc_v), .mem_data_cmd_addr_i(addr),
    .mem_data_cmd_payload_i(payload), .mem_data_cmd_data_i(wdata),
    .mem_data_cmd_yumi_o(a_dc_yumi),
    .mem_resp_v_o(a_resp_v), .mem_resp_addr_o(a_resp_addr),
    .mem_resp_payload_o(a_resp_pl), .mem_resp_ready_i(a_resp_rdy),
    .mem_data_resp_v_o(a_dresp_v), .mem_data_resp_addr_o(a_dresp_addr),
    .mem_data_resp_payload_o(a_dresp_pl), .mem_data_resp_data_o(a_dresp_data),
    .mem_data_resp_ready_i(a_dresp_rdy)
  );

  bp_mem_fixed_latency_responder #(
    .paddr_width_p(40), .block_width_p(64), .payload_width_p(16),
    .els_p(16), .latency_p(1)
  ) dut_b (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_v_i(b_cmd_v), .mem_cmd_addr_i(addr), .mem_cmd_payload_i(payload),
    .mem_cmd_yumi_o(b_cmd_yumi),
    .mem_data_cmd_v_i(b_dc_v), .mem_data_cmd_addr_i(addr),
    .mem_data_cmd_payload_i(payload), .mem_data_cmd_data_i(b_wdata),
    .mem_data_cmd_yumi_o(b_dc_yumi),
    .mem_resp_v_o(b_resp_v), .mem_resp_addr_o(b_resp_addr),
    .mem_resp_payload_o(b_resp_pl), .mem_resp_ready_i(b_resp_rdy),
    .mem_data_resp_v_o(b_dresp_v), .mem_data_resp_addr_o(b_dresp_addr),
    .mem_data_resp_payload_o(b_dresp_pl), .mem_data_resp_data_o(b_dresp_data),
    .mem_data_resp_ready_i(b_dresp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command to instance A, confirm it is consumed, and let the edge take it
  task automatic issue_a(input bit wr, input logic [39:0] a, input logic [15:0] pl,
                         input logic [511:0] d, input string tag);
    addr    = a;
    payload = pl;
    wdata   = d;
    if (wr) a_dc_v = 1'b1; else a_cmd_v = 1'b1;
    #1;
    check(tag, wr ? a_dc_yumi : a_cmd_yumi, 1'b1);
    step();
    a_dc_v  = 1'b0;
    a_cmd_v = 1'b0;
  endtask

  // Count edges from accept until a response valid appears (bounded)
  task automatic wait_resp(input bit sel, input int exp_lat, input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    while (!seen && n < 50) begin
      step();
      n++;
      seen = sel ? (b_resp_v | b_dresp_v) : (a_resp_v | a_dresp_v);
    end
    check(tag, n, exp_lat);
  endtask

  initial begin
    logic [8:0]  yv;
    logic [8:0]  vv;
    logic [63:0] last_b;
    bit          hold_ok;
    bit          seen;

    reset_n = 1'b0;
    addr = '0; payload = '0; wdata = '0; b_wdata = '0;
    a_cmd_v = 1'b1; a_dc_v = 1'b0; a_resp_rdy = 1'b1; a_dresp_rdy = 1'b1;
    b_cmd_v = 1'b0; b_dc_v = 1'b0; b_resp_rdy = 1'b1; b_dresp_rdy = 1'b1;
    #12;
    // Reset state
    check("rst_cmd_yumi", a_cmd_yumi, 1'b0);
    check("rst_resp_v", {a_resp_v, a_dresp_v, b_resp_v, b_dresp_v}, 4'b0);
    check("rst_addr", a_dresp_addr, 40'h0);
    check("rst_data", a_dresp_data, 512'h0);
    a_cmd_v = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    // 1: writeback then read-back, latency 8
    issue_a(1'b1, 40'h40, 16'h1234, D1, "t1_wb_yumi");
    wait_resp(1'b0, 8, "t1_wb_lat");
    check("t1_ack_addr", a_resp_addr, 40'h40);
    check("t1_ack_pl", a_resp_pl, 16'h1234);
    check("t1_ack_only", a_dresp_v, 1'b0);
    step();
    check("t1_ack_drop", a_resp_v, 1'b0);
    issue_a(1'b0, 40'h40, 16'h0055, '0, "t1_rd_yumi");
    wait_resp(1'b0, 8, "t1_rd_lat");
    check("t1_rd_data", a_dresp_data, D1);
    check("t1_rd_addr", a_dresp_addr, 40'h40);
    check("t1_rd_pl", a_dresp_pl, 16'h0055);
    step();

    // 2: read and writeback together; writeback first, read sees its data
    addr = 40'h80; payload = 16'h0A0A; wdata = D2;
    a_dc_v = 1'b1; a_cmd_v = 1'b1;
    #1;
    check("t2_yumi_pair", {a_dc_yumi, a_cmd_yumi}, 2'b10);
    step();
    a_dc_v = 1'b0;
    payload = 16'h0B0B;
    #1;
    check("t2_rd_blocked", a_cmd_yumi, 1'b0);
    wait_resp(1'b0, 8, "t2_wb_lat");
    check("t2_ack_pl", {a_resp_v, a_resp_pl}, {1'b1, 16'h0A0A});
    step();
    check("t2_rd_yumi", a_cmd_yumi, 1'b1);
    step();
    a_cmd_v = 1'b0;
    wait_resp(1'b0, 8, "t2_rd_lat");
    check("t2_rd_data", a_dresp_data, D2);
    check("t2_rd_pl", a_dresp_pl, 16'h0B0B);
    step();

    // 3: backpressure on read data for 20 cycles
    a_dresp_rdy = 1'b0;
    issue_a(1'b0, 40'h40, 16'h0033, '0, "t3_rd_yumi");
    wait_resp(1'b0, 8, "t3_rd_lat");
    addr = 40'h80; payload = 16'h0C0C; a_cmd_v = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!(a_dresp_v === 1'b1 && a_dresp_data === D1 && a_dresp_pl === 16'h0033 &&
            a_dresp_addr === 40'h40 && a_cmd_yumi === 1'b0)) hold_ok = 1'b0;
      step();
    end
    check("t3_hold_stable", hold_ok, 1'b1);
    a_dresp_rdy = 1'b1;
    step();
    check("t3_v_drop", a_dresp_v, 1'b0);
    check("t3_new_yumi", a_cmd_yumi, 1'b1);
    step();
    a_cmd_v = 1'b0;
    wait_resp(1'b0, 8, "t3_new_lat");
    check("t3_new_data", {a_dresp_pl, a_dresp_data}, {16'h0C0C, D2});
    step();

    // 4: aliasing, 0x10000 maps to the same block as 0x0
    issue_a(1'b1, 40'h0, 16'h0004, D4, "t4_wb_yumi");
    wait_resp(1'b0, 8, "t4_wb_lat");
    step();
    issue_a(1'b0, 40'h10000, 16'h0044, '0, "t4_rd_yumi");
    wait_resp(1'b0, 8, "t4_rd_lat");
    check("t4_alias_data", a_dresp_data, D4);
    check("t4_alias_addr", a_dresp_addr, 40'h10000);
    step();

    // 5: latency 1, back-to-back reads -> one transaction every 3 cycles
    addr = 40'h8; payload = 16'h0005; b_wdata = 64'hFEED_0005_CAFE_0001;
    b_dc_v = 1'b1;
    #1;
    check("t5_wb_yumi", b_dc_yumi, 1'b1);
    step();
    b_dc_v = 1'b0;
    wait_resp(1'b1, 1, "t5_wb_lat");
    step();
    b_cmd_v = 1'b1;
    last_b = '0;
    #1;
    for (int k = 0; k < 9; k++) begin
      yv[k] = b_cmd_yumi;
      vv[k] = b_dresp_v;
      if (b_dresp_v) last_b = b_dresp_data;
      step();
    end
    b_cmd_v = 1'b0;
    check("t5_yumi_pattern", yv, 9'b001001001);
    check("t5_v_pattern", vv, 9'b100100100);
    check("t5_data", last_b, 64'hFEED_0005_CAFE_0001);
    step();

    // 6: asynchronous reset in WAIT abandons the read
    issue_a(1'b0, 40'h40, 16'h0066, '0, "t6_rd_yumi");
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_addr", a_dresp_addr, 40'h0);
    check("t6_rst_pl", a_dresp_pl, 16'h0);
    step();
    step();
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (a_resp_v || a_dresp_v) seen = 1'b1;
    end
    check("t6_no_resp", seen, 1'b0);
    issue_a(1'b0, 40'h40, 16'h0067, '0, "t6_after_yumi");
    wait_resp(1'b0, 8, "t6_after_lat");
    check("t6_after_data", a_dresp_data, D1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
